fc_layer_engine: RTL and testbench

Parametrised fully-connected layer engine for the GAN-DPD TDNN datapath. It computes y = act(W·x + b) over IN_DIM Q8.8 inputs and OUT_DIM outputs, with NUM_LANES output neurons evaluated in parallel from a wide weight port. It supports run-time activation select, weight-bank select, saturation reporting and valid/ready handshakes on both sides. Several instances are chained, or one is time-shared, to build generator layers of any size.

---
 rtl/fc_layer_engine.sv | 155 +++++++++++++++
 tb/tb_fc_layer_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: y = act(W*x + b), NUM_LANES neurons per group, weights streamed from a banked memory.
module fc_layer_engine #(
    parameter int IN_DIM       = 18,
    parameter int OUT_DIM      = 32,
    parameter int NUM_LANES    = 4,
    parameter int ACT_WIDTH    = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACC_WIDTH    = 40,
    parameter int FRAC_SHIFT   = 15,
    parameter int LEAKY_SHIFT  = 2,
    parameter int NUM_BANKS    = 4,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ACT_WIDTH*IN_DIM-1:0]       in_vector,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        act_mode,
    input  logic [$clog2(NUM_BANKS)-1:0]      bank_sel,
    output logic [ADDR_WIDTH-1:0]             weight_addr,
    output logic                              weight_rd_en,
    input  logic [NUM_LANES*WEIGHT_WIDTH-1:0] weight_data,
    output logic [ACT_WIDTH*OUT_DIM-1:0]      out_vector,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sat,
    output logic                              busy
);
    localparam int NUM_GROUPS = (OUT_DIM + NUM_LANES - 1) / NUM_LANES;
    localparam int BANK_WORDS = NUM_GROUPS * (IN_DIM + 1);
    localparam int KW = $clog2(IN_DIM + 2);
    localparam int GW = $clog2(NUM_GROUPS + 1);
    localparam int PW = ACT_WIDTH + WEIGHT_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) <<< (ACT_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - 1;
    localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [ACT_WIDTH-1:0] ONE = ACT_WIDTH'(256);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, STORE, DONE} state_t;
    state_t state;

    logic [ACT_WIDTH*IN_DIM-1:0]     x;
    logic [1:0]                      mode;
    logic [GW-1:0]                   g;
    logic [KW-1:0]                   k;
    logic [KW-1:0]                   cons_k;
    logic                            cons_valid;
    logic [ADDR_WIDTH-1:0]           ptr;
    logic [ADDR_WIDTH-1:0]           base;
    logic signed [ACC_WIDTH-1:0]     acc [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]     acc_next [NUM_LANES];
    logic signed [ACT_WIDTH-1:0]     xk;
    logic signed [WEIGHT_WIDTH-1:0]  w [NUM_LANES];
    logic signed [PW-1:0]            prod [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]     bias [NUM_LANES];
    logic signed [ACC_WIDTH-1:0]     rnd [NUM_LANES];
    logic signed [ACT_WIDTH-1:0]     clip [NUM_LANES];
    logic signed [ACT_WIDTH-1:0]     res [NUM_LANES];
    logic [NUM_LANES-1:0]            lane_sat;
    logic [NUM_LANES-1:0]            lane_ok;

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign base     = ADDR_WIDTH'(bank_sel) * ADDR_WIDTH'(BANK_WORDS);

    always_comb begin
        xk = (cons_k < KW'(IN_DIM)) ? x[cons_k*ACT_WIDTH +: ACT_WIDTH] : '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            w[j]        = weight_data[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            prod[j]     = xk * w[j];
            bias[j]     = ACC_WIDTH'(w[j]) <<< FRAC_SHIFT;
            acc_next[j] = acc[j] + ((cons_k == KW'(IN_DIM)) ? bias[j] : ACC_WIDTH'(prod[j]));
            rnd[j]      = (acc[j] + HALF) >>> FRAC_SHIFT;
            lane_sat[j] = rnd[j] > MAXV || rnd[j] < MINV;
            clip[j]     = rnd[j] > MAXV ? MAXV[ACT_WIDTH-1:0] :
                          rnd[j] < MINV ? MINV[ACT_WIDTH-1:0] : rnd[j][ACT_WIDTH-1:0];
            res[j]      = mode == 2'd1 ? (clip[j] < 0 ? clip[j] >>> LEAKY_SHIFT : clip[j]) :
                          mode == 2'd2 ? (clip[j] > ONE ? ONE : clip[j] < -ONE ? -ONE : clip[j]) :
                          clip[j];
            lane_ok[j]  = int'(g) * NUM_LANES + j < OUT_DIM;
        end
    end

    // Read data returns one cycle after the strobe, so consumption trails issue by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            mode         <= '0;
            g            <= '0;
            k            <= '0;
            cons_k       <= '0;
            cons_valid   <= 1'b0;
            ptr          <= '0;
            weight_addr  <= '0;
            weight_rd_en <= 1'b0;
            out_vector   <= '0;
            out_sat      <= 1'b0;
            out_valid    <= 1'b0;
            for (int j = 0; j < NUM_LANES; j++) acc[j] <= '0;
        end else begin
            cons_valid <= weight_rd_en;
            cons_k     <= k;
            if (cons_valid) for (int j = 0; j < NUM_LANES; j++) acc[j] <= acc_next[j];
            case (state)
                IDLE: if (in_valid) begin
                    x            <= in_vector;
                    mode         <= act_mode;
                    g            <= '0;
                    k            <= '0;
                    out_sat      <= 1'b0;
                    weight_rd_en <= 1'b1;
                    weight_addr  <= base;
                    ptr          <= base + 1'b1;
                    state        <= ISSUE;
                    for (int j = 0; j < NUM_LANES; j++) acc[j] <= '0;
                end
                ISSUE: if (k == KW'(IN_DIM)) begin
                    weight_rd_en <= 1'b0;
                    weight_addr  <= '0;
                    state        <= DRAIN;
                end else begin
                    k           <= k + 1'b1;
                    weight_addr <= ptr;
                    ptr         <= ptr + 1'b1;
                end
                DRAIN: state <= STORE;
                STORE: begin
                    for (int j = 0; j < NUM_LANES; j++) begin
                        if (lane_ok[j]) out_vector[(int'(g)*NUM_LANES+j)*ACT_WIDTH +: ACT_WIDTH] <= res[j];
                        acc[j] <= '0;
                    end
                    out_sat <= out_sat | |(lane_sat & lane_ok);
                    k       <= '0;
                    if (g == GW'(NUM_GROUPS - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        g            <= g + 1'b1;
                        weight_rd_en <= 1'b1;
                        weight_addr  <= ptr;
                        ptr          <= ptr + 1'b1;
                        state        <= ISSUE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: scoreboard bench with a banked weight memory model and arithmetic reference.
module tb_fc_layer_engine;
    localparam int ID = 2, OD = 3, NL = 2, NG = 2, BW = NG * (ID + 1), NB = 4;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [16*ID-1:0] in_vector = '0;
    logic             in_valid = 0, in_ready;
    logic [1:0]       act_mode = 0, bank_sel = 0;
    logic [15:0]      weight_addr;
    logic             weight_rd_en;
    logic [NL*16-1:0] weight_data = '0;
    logic [16*OD-1:0] out_vector;
    logic             out_valid, out_ready = 1, out_sat, busy;

    logic [NL*16-1:0] mem [NB*BW];
    int checks = 0, errors = 0, cyc = 0, reads = 0;
    typedef struct {logic [16*OD-1:0] v; logic s; int t;} exp_t;
    exp_t q[$];
    logic [16*OD-1:0] last_v;
    logic last_s;

    fc_layer_engine #(.IN_DIM(ID), .OUT_DIM(OD), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .in_vector(in_vector), .in_valid(in_valid), .in_ready(in_ready),
        .act_mode(act_mode), .bank_sel(bank_sel), .weight_addr(weight_addr), .weight_rd_en(weight_rd_en),
        .weight_data(weight_data), .out_vector(out_vector), .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .busy(busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        weight_data <= weight_rd_en ? mem[weight_addr] : NL*16'($urandom);
    end
    always @(negedge clk) if (weight_rd_en) reads++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [16*ID-1:0] xv, input logic [1:0] m, input int b);
        exp_t e;
        e.v = '0; e.s = 0; e.t = 0;
        for (int n = 0; n < OD; n++) begin
            longint acc = 0, r;
            int base = b * BW + (n / NL) * (ID + 1), j = n % NL;
            for (int kk = 0; kk < ID; kk++)
                acc += longint'($signed(xv[kk*16 +: 16])) * longint'($signed(mem[base+kk][j*16 +: 16]));
            acc += longint'($signed(mem[base+ID][j*16 +: 16])) * 32768;
            r = (acc + 16384) >>> 15;
            if (r > 32767) begin r = 32767; e.s = 1; end
            else if (r < -32768) begin r = -32768; e.s = 1; end
            if (m == 1 && r < 0) r = r >>> 2;
            if (m == 2) r = r > 256 ? 256 : r < -256 ? -256 : r;
            e.v[n*16 +: 16] = 16'(r);
        end
        return e;
    endfunction

    task automatic set_bank(input int b, input logic [15:0] wv, input logic [15:0] bv);
        for (int g = 0; g < NG; g++) begin
            for (int kk = 0; kk < ID; kk++) mem[b*BW + g*(ID+1) + kk] = {NL{wv}};
            mem[b*BW + g*(ID+1) + ID] = {NL{bv}};
        end
    endtask

    task automatic send(input logic [16*ID-1:0] xv, input logic [1:0] m, input logic [1:0] b);
        exp_t e;
        in_vector = xv; act_mode = m; bank_sel = b; in_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept_ready", in_ready, 1);
        e = model(xv, m, int'(b));
        e.t = cyc + 1;
        q.push_back(e);
        reads = 0;
        @(posedge clk); #1 in_valid = 0;
    endtask

    task automatic finish_out(input bit rnd);
        for (int i = 0; i < 100; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) break;
            @(posedge clk); #1;
        end
        chk("out_handshake", out_valid && out_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_vector", out_vector, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_weight_addr", weight_addr, 0);
        chk("rst_weight_rd_en", weight_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    // Monitor: latency on out_valid rise, then vector/sat comparison at each output handshake.
    initial begin
        bit pv = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && !pv) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid got out_valid=1 expected 0");
                end else chk("latency", 64'(cyc - q[0].t), 10);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_vector", out_vector, e.v);
                chk("out_sat", out_sat, e.s);
                last_v = out_vector;
                last_s = out_sat;
            end
            pv = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hs;
        logic [16*OD-1:0] v0;
        for (int a = 0; a < NB*BW; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals();
        rst_n = 1;

        set_bank(0, 16'd16384, 16'd0);
        send({16'hFE00, 16'h0100}, 0, 0);
        finish_out(0);
        chk("lin_reads", reads, 6);
        chk("lin_out", last_v, {3{16'hFF80}});
        chk("lin_sat", last_s, 0);
        send({16'hFE00, 16'h0100}, 1, 0);
        finish_out(0);
        chk("leaky_out", last_v, {3{16'hFFE0}});
        send({16'hFE00, 16'h0100}, 2, 0);
        finish_out(0);
        chk("htanh_out", last_v, {3{16'hFF80}});

        set_bank(0, 16'd32767, 16'd32767);
        send({16'h7FFF, 16'h7FFF}, 0, 0);
        finish_out(0);
        chk("sat_lin_out", last_v, {3{16'h7FFF}});
        chk("sat_lin_flag", last_s, 1);
        send({16'h7FFF, 16'h7FFF}, 2, 0);
        finish_out(0);
        chk("sat_htanh_out", last_v, {3{16'h0100}});
        chk("sat_htanh_flag", last_s, 1);

        set_bank(2, 16'd16384, 16'd5);
        send({16'h0000, 16'h0001}, 0, 2);
        @(negedge clk);
        chk("bank_first_addr", weight_addr, 2 * BW);
        chk("bank_first_rd", weight_rd_en, 1);
        finish_out(0);
        chk("bias_round_out", last_v, {3{16'h0006}});

        // Backpressure, then simultaneous out_ready and in_valid in DONE.
        for (int a = BW; a < 2*BW; a++) mem[a] = {$urandom};
        out_ready = 0;
        send({$urandom}, 3, 1);
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        v0 = out_vector;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("bp_stable", out_vector, v0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1; in_valid = 1; in_vector = {$urandom}; act_mode = 0; bank_sel = 1;
        @(negedge clk);
        chk("bp_in_ready_done", in_ready, 0);
        hs = cyc + 1;
        @(posedge clk); #1;
        send(in_vector, 0, 1);
        chk("bp_accept_gap", 64'(cyc - hs), 1);
        chk("bp_busy", busy, 1);
        finish_out(0);

        // Reset during group 1 issue.
        send({$urandom}, 1, 1);
        repeat (6) @(posedge clk);
        #1 rst_n = 0;
        #1 chk_reset_vals();
        q.delete();
        @(posedge clk); #1 rst_n = 1;
        repeat (20) @(posedge clk);
        #1 chk("post_reset_valid", out_valid, 0);
        send({$urandom}, 0, 1);
        finish_out(0);

        for (int it = 0; it < 30; it++) begin
            if (it % 10 == 0) for (int a = 0; a < NB*BW; a++) mem[a] = {$urandom};
            send({$urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            finish_out(1);
        end
        out_ready = 1;
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
